// File: rtl/xm_pkg.sv
// Shared XMODEM (checksum variant) protocol codes, block geometry and controller
// state encoding for the scene loader.
package xm_pkg;

   localparam logic [7:0] SOH = 8'h01;
   localparam logic [7:0] EOT = 8'h04;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   localparam logic [7:0] CAN = 8'h18;

   localparam int XM_BLK_BYTES = 128;

   // 100 MHz system clock over 115200 baud, shared with the UART blocks
   localparam int XM_CYC_PER_BIT = 868;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_NAK,
      ST_WAIT_SOH,
      ST_BLK,
      ST_BLK_N,
      ST_DATA,
      ST_CKSUM,
      ST_COMMIT,
      ST_SEND_ACK,
      ST_SEND_CAN,
      ST_DONE,
      ST_ERROR
   } xm_state_t;

endpackage

// File: rtl/xm_block_buf.sv
// 128x8 holding buffer for one XMODEM payload: filled while the block arrives,
// drained to scene memory only once the block has validated.
module xm_block_buf
   import xm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   input  logic       rd_adv,
   output logic [7:0] rd_data
);

   logic [7:0] mem [XM_BLK_BYTES];
   logic [6:0] wptr;
   logic [6:0] rptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clr) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en)
            wptr <= wptr + 7'd1;
         if (rd_adv)
            rptr <= rptr + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr] <= wr_data;
   end

   // full marks the slot of the 128th payload byte, so the write that sees it completes the block
   assign full    = (wptr == 7'd127);
   assign rd_data = mem[rptr];

endmodule

// File: rtl/xm_scene_loader_ctrl.sv
// XMODEM checksum receiver that validates each 128-byte block before streaming it
// into scene memory, answering the sender with ACK/NAK/CAN.
module xm_scene_loader_ctrl
   import xm_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 2_000_000,
   parameter int MAX_RETRIES = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic              loading,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   bytes_loaded
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int RTY_W = $clog2(MAX_RETRIES + 1);
   localparam logic [ADDR_W+1:0] MEM_BYTES = (ADDR_W+2)'(1) << ADDR_W;

   xm_state_t        state;
   logic [7:0]       expected;
   logic [7:0]       blk;
   logic [7:0]       blk_n;
   logic [7:0]       cksum;
   logic [RTY_W-1:0] retries;
   logic [TMR_W-1:0] timer;
   logic             eot_ack;

   logic             counting;
   logic             timed_out;
   logic             retry_cap;
   logic             hdr_ok;
   logic             sum_ok;
   logic             overflow;
   logic             commit_go;
   logic             retry_fail;
   logic             last_accept;
   logic             buf_clr;
   logic             buf_wr;
   logic             buf_full;
   logic             buf_rd_adv;
   logic [7:0]       buf_rd_data;

   assign counting    = (state inside {ST_WAIT_SOH, ST_BLK, ST_BLK_N, ST_DATA, ST_CKSUM});
   assign timed_out   = counting && !rx_valid && (timer == TMR_W'(TIMEOUT_CYC - 1));
   assign retry_cap   = (retries >= RTY_W'(MAX_RETRIES - 1));
   assign hdr_ok      = ((blk ^ blk_n) == 8'hFF);
   assign sum_ok      = (rx_data == cksum);
   assign overflow    = ({1'b0, bytes_loaded} + (ADDR_W+2)'(XM_BLK_BYTES)) > MEM_BYTES;
   assign commit_go   = (state == ST_CKSUM) && rx_valid && hdr_ok && sum_ok &&
                        (blk == expected) && !overflow;
   assign retry_fail  = timed_out || ((state == ST_CKSUM) && rx_valid && !(hdr_ok && sum_ok));
   // commits always start on a block boundary, so the low address bits count the block bytes
   assign last_accept = (wr_addr[6:0] == 7'h7F);
   assign buf_clr     = (state == ST_WAIT_SOH) && rx_valid && (rx_data == SOH);
   assign buf_wr      = (state == ST_DATA) && rx_valid;
   assign buf_rd_adv  = commit_go || ((state == ST_COMMIT) && wr_ready && !last_accept);

   xm_block_buf u_block_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_data (rx_data),
      .full    (buf_full),
      .rd_adv  (buf_rd_adv),
      .rd_data (buf_rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         tx_valid     <= 1'b0;
         tx_data      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         loading      <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         bytes_loaded <= '0;
         expected     <= 8'd1;
         retries      <= '0;
         timer        <= '0;
         blk          <= '0;
         blk_n        <= '0;
         cksum        <= '0;
         eot_ack      <= 1'b0;
      end else begin
         if (!counting || rx_valid || timed_out)
            timer <= '0;
         else
            timer <= timer + TMR_W'(1);

         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  bytes_loaded <= '0;
                  wr_addr      <= '0;
                  retries      <= '0;
                  cksum        <= '0;
                  expected     <= 8'd1;
                  eot_ack      <= 1'b0;
                  loading      <= 1'b1;
                  load_done    <= 1'b0;
                  load_error   <= 1'b0;
                  tx_valid     <= 1'b1;
                  tx_data      <= NAK;
                  state        <= ST_SEND_NAK;
               end
            end
            ST_SEND_NAK: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= ST_WAIT_SOH;
               end
            end
            ST_SEND_ACK: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  if (eot_ack) begin
                     loading   <= 1'b0;
                     load_done <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_WAIT_SOH;
                  end
               end
            end
            ST_SEND_CAN: begin
               if (tx_valid && tx_ready) begin
                  tx_valid   <= 1'b0;
                  loading    <= 1'b0;
                  load_error <= 1'b1;
                  state      <= ST_ERROR;
               end
            end
            ST_WAIT_SOH: begin
               if (rx_valid) begin
                  if (rx_data == SOH) begin
                     cksum <= '0;
                     state <= ST_BLK;
                  end else if (rx_data == EOT) begin
                     eot_ack  <= 1'b1;
                     tx_valid <= 1'b1;
                     tx_data  <= ACK;
                     state    <= ST_SEND_ACK;
                  end
               end
            end
            ST_BLK: begin
               if (rx_valid) begin
                  blk   <= rx_data;
                  state <= ST_BLK_N;
               end
            end
            ST_BLK_N: begin
               if (rx_valid) begin
                  blk_n <= rx_data;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  cksum <= cksum + rx_data;
                  if (buf_full)
                     state <= ST_CKSUM;
               end
            end
            ST_CKSUM: begin
               // corrupt header/checksum is handled by the retry path below
               if (rx_valid && hdr_ok && sum_ok) begin
                  if (blk == expected) begin
                     if (overflow) begin
                        tx_valid <= 1'b1;
                        tx_data  <= CAN;
                        state    <= ST_SEND_CAN;
                     end else begin
                        wr_en   <= 1'b1;
                        wr_data <= buf_rd_data;
                        state   <= ST_COMMIT;
                     end
                  end else if (blk == expected - 8'd1) begin
                     tx_valid <= 1'b1;
                     tx_data  <= ACK;
                     state    <= ST_SEND_ACK;
                  end else begin
                     tx_valid <= 1'b1;
                     tx_data  <= CAN;
                     state    <= ST_SEND_CAN;
                  end
               end
            end
            ST_COMMIT: begin
               if (wr_en && wr_ready) begin
                  wr_addr <= wr_addr + ADDR_W'(1);
                  if (last_accept) begin
                     wr_en        <= 1'b0;
                     expected     <= expected + 8'd1;
                     bytes_loaded <= bytes_loaded + (ADDR_W+1)'(XM_BLK_BYTES);
                     retries      <= '0;
                     tx_valid     <= 1'b1;
                     tx_data      <= ACK;
                     state        <= ST_SEND_ACK;
                  end else begin
                     wr_data <= buf_rd_data;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (retry_fail) begin
            retries  <= retries + RTY_W'(1);
            tx_valid <= 1'b1;
            tx_data  <= retry_cap ? CAN : NAK;
            state    <= retry_cap ? ST_SEND_CAN : ST_SEND_NAK;
         end
      end
   end

endmodule

// File: tb/tb_xm_scene_loader_ctrl.sv
// Directed bench for the XMODEM scene loader: timeouts, good/bad/duplicate blocks,
// out-of-sequence abort, write back-pressure and reset during commit.
module tb_xm_scene_loader_ctrl;
   import xm_pkg::*;

   localparam int ADDR_W = 16;
   localparam int TMO    = 64;
   localparam int MAXR   = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              wr_ready;
   logic              loading;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   bytes_loaded;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int c;
   int c_prev;

   logic [7:0]        tx_q  [$];
   int                txc_q [$];
   logic [ADDR_W-1:0] wa_q  [$];
   logic [7:0]        wd_q  [$];

   xm_scene_loader_ctrl #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TMO),
      .MAX_RETRIES (MAXR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .wr_ready     (wr_ready),
      .loading      (loading),
      .load_done    (load_done),
      .load_error   (load_error),
      .bytes_loaded (bytes_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // inputs change 1 time unit after posedge, so negedge shows what the next edge accepts
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         txc_q.push_back(cyc);
      end
      if (wr_en && wr_ready) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_block(input logic [7:0] bn, input logic [7:0] bnc,
                             input logic [7:0] base, input logic [7:0] cks_adj);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'h00;
      send_byte(SOH);
      send_byte(bn);
      send_byte(bnc);
      for (int i = 0; i < 128; i++) begin
         b = base + 8'(i);
         s = s + b;
         send_byte(b);
      end
      send_byte(s + cks_adj);
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] exp, input int budget,
                            output int at_cyc);
      int n;
      logic [7:0] got;
      n = 0;
      while (tx_q.size() == 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'(tx_q.size() > 0), 32'd1);
      at_cyc = 0;
      if (tx_q.size() > 0) begin
         got    = tx_q.pop_front();
         at_cyc = txc_q.pop_front();
         check(tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      tx_q.delete();
      txc_q.delete();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_tx_valid"}, tx_valid, 0);
      check({pfx, "_tx_data"}, tx_data, 0);
      check({pfx, "_wr_en"}, wr_en, 0);
      check({pfx, "_wr_addr"}, wr_addr, 0);
      check({pfx, "_wr_data"}, wr_data, 0);
      check({pfx, "_loading"}, loading, 0);
      check({pfx, "_load_done"}, load_done, 0);
      check({pfx, "_load_error"}, load_error, 0);
      check({pfx, "_bytes_loaded"}, bytes_loaded, 0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      wr_ready = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      tick();

      // timeouts: initial NAK, nine timeout NAKs each TMO idle cycles apart, CAN on the tenth
      clear_logs();
      pulse_start();
      check("a_nak_lat_valid", tx_valid, 1);
      check("a_nak_lat_data", tx_data, NAK);
      check("a_loading", loading, 1);
      expect_tx("a_nak0", NAK, 4, c_prev);
      for (int k = 1; k < MAXR; k++) begin
         expect_tx($sformatf("a_nak%0d", k), NAK, TMO + 8, c);
         check($sformatf("a_gap%0d", k), c - c_prev, TMO + 1);
         c_prev = c;
      end
      expect_tx("a_can", CAN, TMO + 8, c);
      check("a_can_gap", c - c_prev, TMO + 1);
      check("a_load_error", load_error, 1);
      check("a_loading_off", loading, 0);
      check("a_load_done", load_done, 0);

      // two good blocks then EOT
      clear_logs();
      pulse_start();
      check("b_err_cleared", load_error, 0);
      expect_tx("b_nak", NAK, 4, c);
      send_block(8'd1, 8'hFE, 8'd0, 8'd0);
      check("b_commit_wr_en", wr_en, 1);
      check("b_commit_first", wr_data, 0);
      expect_tx("b_ack1", ACK, 200, c);
      send_block(8'd2, 8'hFD, 8'd128, 8'd0);
      expect_tx("b_ack2", ACK, 200, c);
      send_byte(EOT);
      check("b_eot_lat", tx_valid, 1);
      expect_tx("b_ack_eot", ACK, 4, c);
      check("b_load_done", load_done, 1);
      check("b_loading_off", loading, 0);
      check("b_bytes_loaded", bytes_loaded, 256);
      check("b_nwrites", wa_q.size(), 256);
      for (int i = 0; i < wa_q.size() && i < 256; i++) begin
         check($sformatf("b_addr%0d", i), wa_q[i], i);
         check($sformatf("b_data%0d", i), wd_q[i], i);
      end

      // bad checksum, good resend, then a duplicate
      clear_logs();
      pulse_start();
      check("c_done_cleared", load_done, 0);
      check("c_bytes_cleared", bytes_loaded, 0);
      expect_tx("c_nak0", NAK, 4, c);
      send_block(8'd1, 8'hFE, 8'd0, 8'hFF);
      check("c_badsum_lat_valid", tx_valid, 1);
      check("c_badsum_lat_data", tx_data, NAK);
      expect_tx("c_badsum_nak", NAK, 4, c);
      check("c_badsum_nwrites", wa_q.size(), 0);
      send_block(8'd1, 8'hFE, 8'd0, 8'd0);
      expect_tx("c_ack", ACK, 200, c);
      check("c_nwrites", wa_q.size(), 128);
      check("c_bytes_loaded", bytes_loaded, 128);
      for (int i = 0; i < wa_q.size() && i < 128; i++) begin
         check($sformatf("c_addr%0d", i), wa_q[i], i);
         check($sformatf("c_data%0d", i), wd_q[i], i);
      end
      send_block(8'd1, 8'hFE, 8'd0, 8'd0);
      check("d_dup_lat_valid", tx_valid, 1);
      check("d_dup_lat_data", tx_data, ACK);
      expect_tx("d_dup_ack", ACK, 4, c);
      check("d_nwrites", wa_q.size(), 128);
      check("d_bytes_loaded", bytes_loaded, 128);
      send_byte(EOT);
      expect_tx("d_ack_eot", ACK, 4, c);
      check("d_load_done", load_done, 1);

      // out-of-sequence block aborts
      clear_logs();
      pulse_start();
      expect_tx("e_nak", NAK, 4, c);
      send_block(8'd1, 8'hFE, 8'd0, 8'd0);
      expect_tx("e_ack", ACK, 200, c);
      send_block(8'd3, 8'hFC, 8'd0, 8'd0);
      check("e_can_lat_valid", tx_valid, 1);
      check("e_can_lat_data", tx_data, CAN);
      expect_tx("e_can", CAN, 4, c);
      check("e_load_error", load_error, 1);
      check("e_bytes_loaded", bytes_loaded, 128);
      check("e_nwrites", wa_q.size(), 128);

      // bad complement byte
      clear_logs();
      pulse_start();
      expect_tx("f_nak0", NAK, 4, c);
      send_block(8'd1, 8'h00, 8'd0, 8'd0);
      expect_tx("f_badhdr_nak", NAK, 4, c);
      check("f_nwrites", wa_q.size(), 0);

      // memory back-pressure: five stalled cycles before each accept
      wr_ready = 1'b0;
      send_block(8'd1, 8'hFE, 8'd0, 8'd0);
      for (int k = 0; k < 128; k++) begin
         repeat (5) begin
            check("g_stall_en", wr_en, 1);
            check("g_stall_addr", wr_addr, k);
            check("g_stall_data", wr_data, k);
            check("g_stall_no_ack", tx_valid, 0);
            tick();
         end
         wr_ready = 1'b1;
         tick();
         wr_ready = 1'b0;
      end
      check("g_ack_lat_valid", tx_valid, 1);
      check("g_ack_lat_data", tx_data, ACK);
      check("g_wr_en_off", wr_en, 0);
      expect_tx("g_ack", ACK, 4, c);
      check("g_bytes_loaded", bytes_loaded, 128);

      // reset in the middle of the second block's commit
      send_block(8'd2, 8'hFD, 8'd128, 8'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         wr_ready = 1'b1;
         tick();
         wr_ready = 1'b0;
      end
      check("h_mid_addr", wr_addr, 131);
      check("h_mid_data", wr_data, 131);
      rst = 1'b1;
      #1;
      check_reset_outputs("h_rst");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // start and a byte together in IDLE: start is taken
      clear_logs();
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = SOH;
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
      check("i_start_lat_valid", tx_valid, 1);
      check("i_start_lat_data", tx_data, NAK);
      check("i_loading", loading, 1);
      expect_tx("i_nak", NAK, 4, c);
      check("i_bytes_loaded", bytes_loaded, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
